// File: rtl/sn_api_arbiter.sv
// Grant side of the Axon Protocol Interface: round-robin one-hot grants during a transmit
// period, api_vld generation and api_bus protocol monitoring.
module sn_api_arbiter #(
   parameter int P_NUM_NEURONS = 100,
   parameter int P_NUM_OUTPUTS = 3
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic                                                  nc_reset,
   input  logic                                                  xmit_start,
   output logic                                                  xmit_done,
   output logic                                                  busy,
   input  logic [P_NUM_NEURONS-P_NUM_OUTPUTS-1:0]                api_pending,
   output logic [P_NUM_NEURONS-P_NUM_OUTPUTS-1:0]                api_granted,
   output logic                                                  api_vld,
   input  logic [$clog2(P_NUM_NEURONS-P_NUM_OUTPUTS+1)-1:0]      api_bus,
   output logic [$clog2(P_NUM_NEURONS-P_NUM_OUTPUTS+1)-1:0]      spike_cnt,
   output logic                                                  proto_err
);

   localparam int L_NUM_SENDERS = P_NUM_NEURONS - P_NUM_OUTPUTS;
   localparam int L_BUS_BW      = $clog2(P_NUM_NEURONS - P_NUM_OUTPUTS + 1);
   localparam int L_CNT_BW      = $clog2(L_NUM_SENDERS + 1);
   localparam int L_PTR_BW      = (L_NUM_SENDERS > 1) ? $clog2(L_NUM_SENDERS) : 1;

   localparam logic [L_PTR_BW-1:0]      L_LAST = L_PTR_BW'(L_NUM_SENDERS - 1);
   localparam logic [L_NUM_SENDERS-1:0] L_ONE  = L_NUM_SENDERS'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XMIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]               state;
   logic [L_NUM_SENDERS-1:0] grant_q;
   logic [L_PTR_BW-1:0]      rr_ptr;

   logic [L_NUM_SENDERS-1:0] cand;
   logic                     sel_found;
   logic [L_PTR_BW-1:0]      sel_idx;
   logic [L_PTR_BW-1:0]      ptr_nxt;
   logic [L_NUM_SENDERS-1:0] grant_nxt;
   logic [L_BUS_BW-1:0]      grant_idx;

   // The sender granted this cycle still shows pending; mask it so grants can run back-to-back.
   assign cand = api_pending & ~grant_q;

   always_comb begin
      int unsigned pos;
      pos       = 0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int unsigned i = 0; i < L_NUM_SENDERS; i++) begin
         pos = int'(rr_ptr) + i;
         if (pos >= L_NUM_SENDERS) pos = pos - L_NUM_SENDERS;
         if (!sel_found && cand[pos[L_PTR_BW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = pos[L_PTR_BW-1:0];
         end
      end
   end

   assign ptr_nxt   = (sel_idx == L_LAST) ? '0 : sel_idx + L_PTR_BW'(1);
   assign grant_nxt = L_ONE << sel_idx;

   always_comb begin
      grant_idx = '0;
      for (int unsigned i = 0; i < L_NUM_SENDERS; i++) begin
         if (grant_q[i]) grant_idx = L_BUS_BW'(i + 1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         grant_q   <= '0;
         rr_ptr    <= '0;
         spike_cnt <= '0;
         proto_err <= 1'b0;
      end else begin
         if (api_vld && (api_bus != grant_idx)) proto_err <= 1'b1;
         if (nc_reset) begin
            grant_q <= '0;
            state   <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (xmit_start) begin
                     if (sel_found) begin
                        grant_q   <= grant_nxt;
                        rr_ptr    <= ptr_nxt;
                        spike_cnt <= L_CNT_BW'(1);
                        state     <= ST_XMIT;
                     end else begin
                        spike_cnt <= '0;
                        state     <= ST_DONE;
                     end
                  end
               end
               ST_XMIT: begin
                  if (sel_found) begin
                     grant_q   <= grant_nxt;
                     rr_ptr    <= ptr_nxt;
                     spike_cnt <= spike_cnt + L_CNT_BW'(1);
                  end else begin
                     grant_q <= '0;
                     state   <= ST_DONE;
                  end
               end
               ST_DONE: state <= ST_IDLE;
               default: begin
                  grant_q <= '0;
                  state   <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign api_granted = grant_q;
   assign api_vld     = |grant_q;
   assign xmit_done   = (state == ST_DONE);
   assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_sn_api_arbiter.sv
// Directed bench for sn_api_arbiter with four senders (7 neurons, 3 outputs).
module tb_sn_api_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       nc_reset;
   logic       xmit_start;
   logic       xmit_done;
   logic       busy;
   logic [3:0] api_pending;
   logic [3:0] api_granted;
   logic       api_vld;
   logic [2:0] api_bus;
   logic [2:0] spike_cnt;
   logic       proto_err;
   logic       bus_bad;

   int total = 0;
   int bad   = 0;

   sn_api_arbiter #(.P_NUM_NEURONS(7), .P_NUM_OUTPUTS(3)) dut (
      .clk(clk), .rst(rst), .nc_reset(nc_reset), .xmit_start(xmit_start),
      .xmit_done(xmit_done), .busy(busy), .api_pending(api_pending),
      .api_granted(api_granted), .api_vld(api_vld), .api_bus(api_bus),
      .spike_cnt(spike_cnt), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   // Granted sender drives its index on the bus, optionally corrupted.
   always_comb begin
      api_bus = '0;
      for (int i = 0; i < 4; i++) if (api_granted[i]) api_bus = 3'(i + 1);
      if (bus_bad) api_bus = 3'd5;
   end

   // A granted sender drops its pending one cycle after the grant.
   always @(posedge clk) api_pending <= api_pending & ~api_granted;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "time limit reached");
   end

   initial begin
      rst = 1'b1; nc_reset = 1'b0; xmit_start = 1'b0; bus_bad = 1'b0; api_pending = 4'hF;
      tick(); tick();
      chk("rst_granted", api_granted, 4'h0);
      chk("rst_vld", api_vld, 1'b0);
      chk("rst_done", xmit_done, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_cnt", spike_cnt, 3'd0);
      chk("rst_err", proto_err, 1'b0);
      rst = 1'b0; api_pending = 4'h0;
      tick();

      // two pending, ptr at 0
      api_pending = 4'b1010; xmit_start = 1'b1;
      tick(); xmit_start = 1'b0;
      chk("t2_g1", api_granted, 4'b0010);
      chk("t2_vld1", api_vld, 1'b1);
      chk("t2_bus1", api_bus, 3'd2);
      chk("t2_busy", busy, 1'b1);
      tick();
      chk("t2_g2", api_granted, 4'b1000);
      chk("t2_bus2", api_bus, 3'd4);
      tick();
      chk("t2_g3", api_granted, 4'b0000);
      chk("t2_vld3", api_vld, 1'b0);
      chk("t2_done", xmit_done, 1'b1);
      chk("t2_cnt", spike_cnt, 3'd2);
      tick();
      chk("t2_done_off", xmit_done, 1'b0);
      chk("t2_idle", busy, 1'b0);

      // nothing pending
      api_pending = 4'b0000; xmit_start = 1'b1;
      tick(); xmit_start = 1'b0;
      chk("t3_done", xmit_done, 1'b1);
      chk("t3_vld", api_vld, 1'b0);
      chk("t3_cnt", spike_cnt, 3'd0);
      tick();
      chk("t3_done_off", xmit_done, 1'b0);

      // single grant of bit1 leaves rr_ptr at 2
      api_pending = 4'b0010; xmit_start = 1'b1;
      tick(); xmit_start = 1'b0;
      chk("t4_pre", api_granted, 4'b0010);
      tick(); tick();

      api_pending = 4'b1111; xmit_start = 1'b1;
      tick(); xmit_start = 1'b0;
      chk("t4_g1", api_granted, 4'b0100);
      tick();
      chk("t4_g2", api_granted, 4'b1000);
      tick();
      chk("t4_g3", api_granted, 4'b0001);
      tick();
      chk("t4_g4", api_granted, 4'b0010);
      chk("t4_bus4", api_bus, 3'd2);
      tick();
      chk("t4_done", xmit_done, 1'b1);
      chk("t4_cnt", spike_cnt, 3'd4);
      chk("t4_err", proto_err, 1'b0);
      tick();

      // corrupted bus on grant of bit0 (ptr=2 wraps to 0)
      api_pending = 4'b0001; bus_bad = 1'b1; xmit_start = 1'b1;
      tick(); xmit_start = 1'b0;
      chk("t5_g", api_granted, 4'b0001);
      chk("t5_err_pre", proto_err, 1'b0);
      tick(); bus_bad = 1'b0;
      chk("t5_err", proto_err, 1'b1);
      tick();
      chk("t5_err_after", proto_err, 1'b1);
      nc_reset = 1'b1;
      tick(); nc_reset = 1'b0;
      chk("t5_err_ncr", proto_err, 1'b1);
      rst = 1'b1;
      tick(); rst = 1'b0;
      chk("t5_err_rst", proto_err, 1'b0);
      chk("t5_cnt_rst", spike_cnt, 3'd0);

      // nc_reset mid-period; a second xmit_start during XMIT is ignored
      api_pending = 4'b0111; xmit_start = 1'b1;
      tick();
      chk("t6_g1", api_granted, 4'b0001);
      tick(); xmit_start = 1'b0;
      chk("t6_g2", api_granted, 4'b0010);
      nc_reset = 1'b1;
      tick(); nc_reset = 1'b0;
      chk("t6_g_abort", api_granted, 4'b0000);
      chk("t6_busy", busy, 1'b0);
      chk("t6_done", xmit_done, 1'b0);
      chk("t6_cnt", spike_cnt, 3'd2);
      tick();
      chk("t6_done2", xmit_done, 1'b0);
      chk("t6_g_idle", api_granted, 4'b0000);
      api_pending = 4'b0000;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
